// File: rtl/control_unit_if.sv
// Fetch handshake and ALU operand/result bundle between control_unit and its neighbours.
interface control_unit_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_c;
  logic        alu_cmp;

  modport master (
    output imem_req, imem_addr, alu_sel, alu_a, alu_b,
    input  imem_ack, imem_data, alu_c, alu_cmp
  );

  modport slave (
    input  imem_req, imem_addr, alu_sel, alu_a, alu_b,
    output imem_ack, imem_data, alu_c, alu_cmp
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/execute sequencer for the 8-bit CPU: owns PC, IR and a 4x8 register file,
// decodes IR straight onto the ALU and retires on the EXEC edge.
module control_unit (
  input  logic              clk,
  input  logic              rst,
  control_unit_if.master    bus,
  output logic              halted,
  input  logic [1:0]        dbg_addr,
  output logic [7:0]        dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      pc;
  logic [15:0]     ir;
  logic [3:0][7:0] regs;

  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic       is_branch;

  assign op  = ir[15:12];
  assign rd  = ir[11:10];
  assign rs  = ir[9:8];
  assign imm = ir[7:0];
  // JMP rides the branch path: the ALU reports cmp=1 for it
  assign is_branch = (op >= 4'd10) && (op <= 4'd14);

  assign bus.imem_addr = pc;
  assign bus.alu_sel   = op;
  assign bus.alu_a     = regs[rd];
  assign bus.alu_b     = (op == 4'd0) ? imm : regs[rs];
  assign dbg_data      = regs[dbg_addr];

  always_comb begin
    state_nxt    = state;
    bus.imem_req = 1'b0;
    halted       = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = (op == 4'hF) ? S_HALT : S_FETCH;
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= 8'h00;
      ir    <= 16'h0000;
      regs  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.imem_ack) ir <= bus.imem_data;
      if (state == S_EXEC) begin
        if (op <= 4'd9) regs[rd] <= bus.alu_c;
        if (is_branch)        pc <= bus.alu_cmp ? imm : pc + 8'd1;
        else if (op != 4'hF)  pc <= pc + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed + randomized bench for control_unit against an instruction-level CPU model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       halted;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  control_unit_if bus();

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .halted   (halted),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #10 clk = ~clk;

  // ALU8bit stand-in
  always_comb begin
    bus.alu_c   = 8'h00;
    bus.alu_cmp = 1'b1;
    case (bus.alu_sel)
      4'd0:  bus.alu_c = bus.alu_b;
      4'd1:  bus.alu_c = ~bus.alu_a;
      4'd2:  bus.alu_c = bus.alu_a & bus.alu_b;
      4'd3:  bus.alu_c = bus.alu_a | bus.alu_b;
      4'd4:  bus.alu_c = bus.alu_a ^ bus.alu_b;
      4'd5:  bus.alu_c = bus.alu_a + bus.alu_b;
      4'd6:  bus.alu_c = bus.alu_a - bus.alu_b;
      4'd7:  bus.alu_c = bus.alu_a << bus.alu_b;
      4'd8:  bus.alu_c = bus.alu_a >> bus.alu_b;
      4'd9:  bus.alu_c = $signed(bus.alu_a) >>> bus.alu_b;
      4'd10: bus.alu_cmp = (bus.alu_a == 8'h00);
      4'd11: bus.alu_cmp = (bus.alu_a != 8'h00);
      4'd12: bus.alu_cmp = ($signed(bus.alu_a) > 0);
      4'd13: bus.alu_cmp = ($signed(bus.alu_a) < 0);
      default: ;
    endcase
  end

  int vecs = 0;
  int errs = 0;

  int          m_reg [4];
  int          m_pc;
  logic [15:0] m_ir;
  bit          m_halt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) m_reg[r] = 0;
    m_pc   = 0;
    m_ir   = 16'h0000;
    m_halt = 1'b0;
  endtask

  // Architectural effect of one instruction, in integer arithmetic.
  task automatic model_step(input logic [15:0] w);
    int op, rd, rs, imm, a, b, sa, res;
    bit take;
    op  = int'(w[15:12]);
    rd  = int'(w[11:10]);
    rs  = int'(w[9:8]);
    imm = int'(w[7:0]);
    a   = m_reg[rd];
    b   = m_reg[rs];
    sa  = (a > 127) ? a - 256 : a;
    res = 0;
    take = 1'b1;
    case (op)
      0:  res = imm;
      1:  res = 255 - a;
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = (a + b) % 256;
      6:  res = (a - b + 256) % 256;
      7:  res = (b > 7) ? 0 : (a << b) & 255;
      8:  res = (b > 7) ? 0 : a >> b;
      9:  res = (sa >>> ((b > 31) ? 31 : b)) & 255;
      10: take = (a == 0);
      11: take = (a != 0);
      12: take = (sa > 0);
      13: take = (sa < 0);
      default: take = 1'b1;
    endcase
    if (op <= 9) m_reg[rd] = res;
    if (op == 15)      m_halt = 1'b1;
    else if (op >= 10) m_pc = take ? imm : (m_pc + 1) % 256;
    else               m_pc = (m_pc + 1) % 256;
  endtask

  task automatic chk_regs(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), {8'h00, dbg_data}, 16'(m_reg[r]));
    end
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH (unless it halts).
  task automatic run_instr(input logic [15:0] w, input int waits, input logic spur);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'($urandom);
      #1;
      chk("wait_req", {15'd0, bus.imem_req}, 16'd1);
      chk("wait_addr", {8'h00, bus.imem_addr}, 16'(m_pc));
      chk("wait_ir", {12'd0, bus.alu_sel}, {12'd0, m_ir[15:12]});
      @(posedge clk); #1;
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = w;
    chk("ack_req", {15'd0, bus.imem_req}, 16'd1);
    chk("ack_addr", {8'h00, bus.imem_addr}, 16'(m_pc));
    @(posedge clk); #1;
    bus.imem_ack  = spur;
    bus.imem_data = 16'($urandom);
    m_ir = w;
    #1;
    chk("exec_req", {15'd0, bus.imem_req}, 16'd0);
    chk("exec_sel", {12'd0, bus.alu_sel}, {12'd0, w[15:12]});
    chk("exec_a", {8'h00, bus.alu_a}, 16'(m_reg[w[11:10]]));
    chk("exec_b", {8'h00, bus.alu_b}, (w[15:12] == 4'd0) ? {8'h00, w[7:0]} : 16'(m_reg[w[9:8]]));
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    model_step(w);
    chk("ret_halted", {15'd0, halted}, {15'd0, m_halt});
    chk("ret_req", {15'd0, bus.imem_req}, {15'd0, !m_halt});
    chk("ret_addr", {8'h00, bus.imem_addr}, 16'(m_pc));
    chk("ret_ir", {12'd0, bus.alu_sel}, {12'd0, w[15:12]});
    chk_regs("ret");
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_addr", {8'h00, bus.imem_addr}, 16'h0);
    chk("rst_sel", {12'd0, bus.alu_sel}, 16'h0);
    chk("rst_a", {8'h00, bus.alu_a}, 16'h0);
    chk("rst_b", {8'h00, bus.alu_b}, 16'h0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk_regs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("idle_req", {15'd0, bus.imem_req}, 16'd0);
    @(posedge clk); #1;
    chk("first_req", {15'd0, bus.imem_req}, 16'd1);
    chk("first_addr", {8'h00, bus.imem_addr}, 16'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    dbg_addr      = 2'd0;
    #3;
    reset_and_start();

    // LDI, ADD, SUB on r1
    run_instr(16'h0405, 0, 1'b0);
    run_instr(16'h5500, 0, 1'b0);
    run_instr(16'h6500, 0, 1'b0);

    // BEQZ taken with r1=0, then not taken with r1=0x0A
    run_instr(16'hA420, 0, 1'b0);
    run_instr(16'h040A, 0, 1'b0);
    run_instr(16'hA420, 0, 1'b0);

    // slow memory plus spurious ack in EXEC
    run_instr(16'h0C33, 3, 1'b1);
    run_instr(16'h0D10, 2, 1'b1);

    // JMP to 0xFF then PC wrap
    run_instr(16'hE0FF, 0, 1'b0);
    run_instr(16'h0000, 1, 1'b0);

    // reset while fetching
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("midfetch_req", {15'd0, bus.imem_req}, 16'd1);
    reset_and_start();

    // HALT is terminal despite ack activity
    run_instr(16'h0477, 0, 1'b0);
    run_instr(16'hF000, 0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      bus.imem_ack  = 1'(i);
      bus.imem_data = 16'($urandom);
      @(posedge clk); #1;
      chk("halt_req", {15'd0, bus.imem_req}, 16'd0);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_addr", {8'h00, bus.imem_addr}, 16'(m_pc));
    end
    bus.imem_ack = 1'b0;
    chk_regs("halt");

    // random programs
    reset_and_start();
    for (int n = 0; n < 250; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, int'($urandom_range(0, 3)), 1'($urandom));
    end
    run_instr(16'hF000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/execute sequencer for the 8-bit CPU; sits directly upstream of `ALU8bit`. It fetches 16-bit instructions from instruction memory over a req/ack handshake and owns the PC and a 4×8 register file. It drives the ALU `sel`/`A`/`B` inputs and consumes `C` (register writeback) and `cmp` (branch decision).

## Interface
- No parameters. Widths are fixed: 8-bit data, 8-bit PC, 16-bit instruction.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request, high only in FETCH.
- `imem_addr` output 8: equals PC.
- `imem_ack` input 1: memory ack; `imem_data` is valid in the same cycle.
- `imem_data` input 16: instruction word.
- `alu_sel` output 4: ALU operation select.
- `alu_a` output 8: ALU operand A.
- `alu_b` output 8: ALU operand B.
- `alu_c` input 8: ALU result.
- `alu_cmp` input 1: ALU compare flag.
- `halted` output 1: high in HALT.
- `dbg_addr` input 2: register-file debug read address.
- `dbg_data` output 8: combinational read of `reg[dbg_addr]`.

## Operation
- IR fields:
  - `op` = ir[15:12]
  - `rd` = ir[11:10]
  - `rs` = ir[9:8]
  - `imm` = ir[7:0]
- Decode is combinational from IR at all times:
  - `alu_sel` = `op`
  - `alu_a` = `reg[rd]`
  - `alu_b` = `imm` when `op` is 0, else `reg[rs]`
- Opcodes:
  - 0: LDI. ALU passes B, so `rd` ← `imm`.
  - 1–9: NOT/AND/OR/XOR/ADD/SUB/SHL/SHR/SAR. `rd` ← `alu_c`. Operand B is the full 8-bit `reg[rs]`, including as a shift amount.
  - 10–13: BEQZ/BNEZ/BGTZ/BLTZ on `reg[rd]`. If `alu_cmp`, PC ← `imm`, else PC ← PC+1. No register write.
  - 14: JMP. The ALU's default `cmp` is 1, so PC ← `imm`.
  - 15: HALT. No register write; PC unchanged.
- For all non-branch, non-halt opcodes, PC ← PC+1 at the end of EXEC.
- PC arithmetic is mod 256: 0xFF+1 = 0x00.
- Register writes happen only on the EXEC edge. `r0` is an ordinary register, not hardwired to zero.
- State machine:
  - IDLE → FETCH unconditionally.
  - FETCH: `imem_req`=1 and `imem_addr`=PC held stable. On a cycle with `imem_ack`=1, IR ← `imem_data` and go to EXEC. Otherwise stay in FETCH.
  - EXEC: perform the writeback and/or PC update, then go to FETCH. For opcode 15, go to HALT instead.
  - HALT: terminal. `imem_req`=0 and `halted`=1 until `rst`.
- `imem_ack` is ignored outside FETCH.
- Reset values, applied asynchronously:
  - state=IDLE, PC=0x00, IR=0x0000, all registers 0x00.
  - Hence `imem_req`=0, `imem_addr`=0, `alu_sel`=0, `alu_a`=0, `alu_b`=0, `halted`=0, `dbg_data`=0.
- Reset mid-fetch or mid-exec: `imem_req` drops in the same cycle `rst` rises. No register write or PC update completes.

## Timing
- The first `imem_req` is seen the 2nd rising edge after `rst` deasserts (IDLE lasts 1 cycle).
- Fetch takes 1 + N cycles, where N is the number of cycles before ack. With ack in the first FETCH cycle, an instruction retires 2 cycles after entering FETCH.
- Throughput: 1 instruction per 2 cycles at zero wait states.
- `imem_req` falls the cycle after ack is sampled, because state has moved to EXEC.
- The ALU is combinational. `alu_c`/`alu_cmp` must settle within the EXEC cycle; they are sampled only at the EXEC edge.
- `dbg_data` reflects a register write on the cycle after the EXEC edge.

## Test plan
- Reset, then memory returns 0x0405 (LDI r1,0x05) with immediate ack:
  - `imem_req` is high on cycle 1 after reset release.
  - `r1`=0x05 and PC=0x01 after the EXEC edge.
  - `alu_sel`=0 and `alu_b`=0x05 during EXEC.
- Sequence 0x0405, 0x5500 (ADD r1,r1), 0x6500 (SUB r1,r1):
  - `r1` steps 0x05 → 0x0A → 0x00.
  - PC ends at 0x03.
  - Each instruction takes 2 cycles.
- With `r1`=0, 0xA420 (BEQZ r1,0x20) → next `imem_addr`=0x20.
- With `r1`=0x0A, the same word → next `imem_addr` = old PC+1. No register changes in either case.
- `imem_ack` delayed 3 cycles:
  - `imem_req` stays high and `imem_addr` stays stable for 4 FETCH cycles.
  - IR is loaded only on the ack cycle.
  - A spurious ack during EXEC is ignored.
- 0xE0FF (JMP 0xFF), then 0x0000 at address 0xFF → next fetch address is 0x00 (PC wrap).
- 0xF000 → `halted`=1, `imem_req` stays 0 for 10+ cycles with `imem_ack` toggling.
- Assert `rst` mid-FETCH → `imem_req`=0 in the same cycle, PC=0x00, all registers read 0 via `dbg_data`.
